// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM states and sign helper shared by the multiply/divide unit
package muldiv_pkg;
    localparam logic [1:0] OP_MULTU = 2'b00;
    localparam logic [1:0] OP_MULT  = 2'b01;
    localparam logic [1:0] OP_DIVU  = 2'b10;
    localparam logic [1:0] OP_DIV   = 2'b11;
    localparam int XW = 128;
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    // Wide enough for a 2*WIDTH product with WIDTH up to 64; callers size-cast the result.
    function automatic logic [XW-1:0] cond_neg(input logic [XW-1:0] v, input logic neg);
        return neg ? ~v + XW'(1) : v;
    endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one shift-add multiply or restoring-divide iteration on unsigned magnitudes
// ports: div selects divide; acc/q are the partial remainder-or-product halves, mcand the
//        multiplicand or divisor; acc_n/q_n are the values after one step
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             div,
    input  logic [WIDTH-1:0] acc,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] mcand,
    output logic [WIDTH-1:0] acc_n,
    output logic [WIDTH-1:0] q_n
);
    logic [WIDTH:0] sum, t, diff;
    // Divide: diff[WIDTH] is the borrow; the partial remainder is always below 2^WIDTH,
    // so even a zero divisor never sets it and the quotient fills with ones.
    always_comb begin
        sum   = {1'b0, acc} + {1'b0, mcand};
        t     = {acc, q[WIDTH-1]};
        diff  = t - {1'b0, mcand};
        acc_n = div ? (diff[WIDTH] ? t[WIDTH-1:0] : diff[WIDTH-1:0])
                    : (q[0] ? sum[WIDTH:1] : {1'b0, acc[WIDTH-1:1]});
        q_n   = div ? {q[WIDTH-2:0], ~diff[WIDTH]}
                    : {(q[0] ? sum[0] : acc[0]), q[WIDTH-1:1]};
    end
endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative MIPS-style MULT/MULTU/DIV/DIVU with HI/LO, one result bit per cycle
// ports: clk, reset (async, active-high); start/op/src_a/src_b launch an op in IDLE or DONE;
//        hi_we/lo_we/wdata write HI/LO while not busy; busy, done pulse, div_zero; hi/lo results
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32,
    localparam int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic             hi_we,
    input  logic             lo_we,
    input  logic [WIDTH-1:0] wdata,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    state_t state, state_n;
    logic [CNT_W-1:0] cnt;
    logic is_div_r, sign_p, sign_r, is_sgn, is_div, sign_a, sign_b, last, accept;
    logic [WIDTH-1:0] acc, q, mcand, acc_n, q_n, a_mag, b_mag, quot, rem;
    logic [2*WIDTH-1:0] prod;
    assign is_sgn = op == OP_MULT || op == OP_DIV;
    assign is_div = op == OP_DIVU || op == OP_DIV;
    assign sign_a = is_sgn & src_a[WIDTH-1];
    assign sign_b = is_sgn & src_b[WIDTH-1];
    assign a_mag  = WIDTH'(cond_neg(XW'(src_a), sign_a));
    assign b_mag  = WIDTH'(cond_neg(XW'(src_b), sign_b));
    assign prod   = (2*WIDTH)'(cond_neg(XW'({acc, q}), sign_p));
    assign quot   = WIDTH'(cond_neg(XW'(q), sign_p));
    assign rem    = WIDTH'(cond_neg(XW'(acc), sign_r));
    assign last   = cnt == CNT_W'(WIDTH - 1);
    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .div   (is_div_r),
        .acc   (acc),
        .q     (q),
        .mcand (mcand),
        .acc_n (acc_n),
        .q_n   (q_n)
    );
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = start ? RUN : IDLE;
            RUN:     state_n = last ? FIX : RUN;
            FIX:     state_n = DONE;
            DONE:    state_n = start ? RUN : IDLE;
            default: state_n = IDLE;
        endcase
        busy   = state == RUN || state == FIX;
        done   = state == DONE;
        accept = start && !busy;
    end
    // Multiply keeps the multiplier in q and the multiplicand in mcand; divide keeps the
    // dividend in q and the divisor in mcand. A zero divisor leaves |src_a| in acc, which the
    // remainder sign fix turns back into src_a exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt      <= '0;
            is_div_r <= 1'b0;
            sign_p   <= 1'b0;
            sign_r   <= 1'b0;
            acc      <= '0;
            q        <= '0;
            mcand    <= '0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
        end else if (accept) begin
            cnt      <= '0;
            is_div_r <= is_div;
            sign_p   <= sign_a ^ sign_b;
            sign_r   <= sign_a;
            acc      <= '0;
            q        <= is_div ? a_mag : b_mag;
            mcand    <= is_div ? b_mag : a_mag;
            div_zero <= 1'b0;
        end else if (state == RUN) begin
            cnt <= cnt + CNT_W'(1);
            acc <= acc_n;
            q   <= q_n;
        end else if (state == FIX) begin
            hi       <= is_div_r ? rem : prod[2*WIDTH-1:WIDTH];
            lo       <= is_div_r ? (mcand == '0 ? '1 : quot) : prod[WIDTH-1:0];
            div_zero <= is_div_r && mcand == '0;
        end else begin
            if (hi_we) hi <= wdata;
            if (lo_we) lo <= wdata;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and random MULT/DIV checks against an arithmetic reference model
module tb_muldiv_unit;
    localparam int W = 32;
    logic clk = 1'b0, reset = 1'b1, start = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
    logic [1:0] op = 2'b00;
    logic [W-1:0] src_a = '0, src_b = '0, wdata = '0;
    logic busy, done, div_zero;
    logic [W-1:0] hi, lo;
    logic [W-1:0] exp_hi, exp_lo;
    logic exp_dz;
    int vectors = 0, miscompares = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .op       (op),
        .src_a    (src_a),
        .src_b    (src_b),
        .hi_we    (hi_we),
        .lo_we    (lo_we),
        .wdata    (wdata),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        exp_dz = 1'b0;
        case (o)
            2'b00: begin p = {32'b0, a} * {32'b0, b}; {exp_hi, exp_lo} = p; end
            2'b01: begin p = sa * sb; {exp_hi, exp_lo} = p; end
            default:
                if (b == 0) begin
                    exp_lo = '1; exp_hi = a; exp_dz = 1'b1;
                end else if (o == 2'b10) begin
                    exp_lo = a / b; exp_hi = a % b;
                end else begin
                    p = sa / sb; exp_lo = p[31:0];
                    p = sa % sb; exp_hi = p[31:0];
                end
        endcase
    endtask

    // we_mode: 0 none, 1 lo_we pulse while busy, 2 lo_we in the same cycle as start
    task automatic run(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input int reissue_at, input int we_mode);
        int k = 0, bad = 0;
        logic [31:0] prev_lo, prev_hi;
        model(o, a, b);
        prev_lo = lo;
        prev_hi = hi;
        op = o; src_a = a; src_b = b; start = 1'b1;
        lo_we = (we_mode == 2);
        wdata = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 start = 1'b0;
        lo_we = 1'b0;
        if (we_mode == 2) check("lo_we_with_start", lo, prev_lo);
        while (k < 60) begin
            @(negedge clk);
            k++;
            if (done) break;
            if (!busy) bad++;
            if (k == 1 && div_zero) bad++;
            if (we_mode == 1 && k == 4) begin
                check("lo_hold_busy", lo, prev_lo);
                check("hi_hold_busy", hi, prev_hi);
            end
            if (k == reissue_at) begin
                start = 1'b1; op = 2'($urandom); src_a = $urandom; src_b = $urandom;
            end else start = 1'b0;
            lo_we = (we_mode == 1 && k == 3);
            wdata = 32'h0BAD_F00D;
        end
        start = 1'b0;
        lo_we = 1'b0;
        check("latency", 32'(k), 32'd34);
        check("busy_window", 32'(bad), 32'd0);
        check("hi", hi, exp_hi);
        check("lo", lo, exp_lo);
        check("div_zero", 32'(div_zero), 32'(exp_dz));
    endtask

    initial begin
        int dones;
        logic [1:0] ro;
        logic [31:0] ra, rb;
        #12;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_dz", 32'(div_zero), 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        run(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("multu_hi_k", hi, 32'hFFFF_FFFE);
        check("multu_lo_k", lo, 32'h0000_0001);
        @(negedge clk);
        run(2'b01, -32'sd3, 32'd7, 0, 0);
        check("mult_lo_k", lo, 32'hFFFF_FFEB);
        run(2'b11, -32'sd7, 32'd2, 0, 0);
        check("div_lo_k", lo, 32'hFFFF_FFFD);
        check("div_hi_k", hi, 32'hFFFF_FFFF);
        @(negedge clk);
        run(2'b10, 32'd5, 32'd0, 0, 0);
        check("divz_dz_k", 32'(div_zero), 32'd1);
        run(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("ovf_lo_k", lo, 32'h8000_0000);
        @(negedge clk);
        run(2'b00, 32'h0001_2345, 32'h0000_6789, 5, 0);
        hi_we = 1'b1; wdata = 32'h0000_CAFE;
        @(posedge clk);
        #1 hi_we = 1'b0;
        check("hi_we_idle", hi, 32'h0000_CAFE);
        run(2'b00, $urandom, $urandom, 0, 1);
        @(negedge clk);
        run(2'b01, $urandom, $urandom, 0, 2);
        hi_we = 1'b1; lo_we = 1'b1; wdata = 32'h0000_1234;
        @(posedge clk);
        #1 hi_we = 1'b0; lo_we = 1'b0;
        check("both_we_hi", hi, 32'h0000_1234);
        check("both_we_lo", lo, 32'h0000_1234);
        op = 2'b11; src_a = 32'd1000; src_b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (10) @(negedge clk);
        check("hi_hold_run", hi, 32'h0000_1234);
        #1 reset = 1'b1;
        #1;
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_hi", hi, 32'd0);
        check("mid_rst_lo", lo, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (done) dones++;
        end
        check("no_done_after_rst", 32'(dones), 32'd0);
        for (int i = 0; i < 40; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = 32'd0;
                1: rb = 32'hFFFF_FFFF;
                2: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                3: rb = $urandom_range(1, 20);
                4: ra = -32'($urandom_range(0, 100));
                default: ;
            endcase
            run(ro, ra, rb, 0, 0);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
